// File: rtl/fifo_arb_pkg.sv
// fifo_arb_pkg: shared state type, default sizes and round-robin search for the FIFO write arbiter.
package fifo_arb_pkg;

    typedef enum logic {IDLE, GRANT} arb_state_e;

    localparam int DEF_NUM_REQ    = 4;
    localparam int DEF_FIFO_WIDTH = 16;
    localparam int DEF_BURST_LEN  = 4;

    // Returns {found, idx[2:0]}: first valid index scanning from last+1, wrapping modulo n (n <= 8).
    function automatic logic [3:0] rr_pick(input logic [7:0] valid, input logic [2:0] last, input int n);
        logic [3:0] r;
        int c;
        r = '0;
        for (int k = 1; k <= 8; k++) begin
            c = (int'(last) + k) % n;
            if (k <= n && !r[3] && valid[c[2:0]])
                r = {1'b1, c[2:0]};
        end
        return r;
    endfunction

endpackage

// File: rtl/fifo_wr_arbiter_picker.sv
// rr_priority_picker: combinational round-robin search starting after the given index.
module rr_priority_picker
    import fifo_arb_pkg::*;
#(
    parameter int NUM_REQ = DEF_NUM_REQ,
    parameter int IW      = 2
) (
    input  logic [NUM_REQ-1:0] valid,
    input  logic [IW-1:0]      last,
    output logic [IW-1:0]      idx,
    output logic               found
);

    logic [3:0] r;

    always_comb r = rr_pick(8'(valid), 3'(last), NUM_REQ);

    assign idx   = IW'(r[2:0]);
    assign found = r[3];

endmodule

// File: rtl/fifo_wr_arbiter.sv
// fifo_wr_arbiter: round-robin burst arbiter sharing one FIFO write port between NUM_REQ producers.
// Optional per-producer beat and stall counters are built when FIFO_ARB_STATS_EN is defined.
module fifo_wr_arbiter
    import fifo_arb_pkg::*;
#(
    parameter int NUM_REQ    = DEF_NUM_REQ,
    parameter int FIFO_WIDTH = DEF_FIFO_WIDTH,
    parameter int BURST_LEN  = DEF_BURST_LEN
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic [NUM_REQ-1:0]            req_valid,
    input  logic [NUM_REQ*FIFO_WIDTH-1:0] req_data,
    output logic [NUM_REQ-1:0]            req_ready,
    output logic [NUM_REQ-1:0]            gnt,
    output logic [FIFO_WIDTH-1:0]         fifo_data_in,
    output logic                          fifo_wr_en,
    input  logic                          fifo_full,
    input  logic                          fifo_overflow,
    output logic                          busy,
    output logic                          err_overflow
`ifdef FIFO_ARB_STATS_EN
   ,output logic [NUM_REQ*16-1:0]         stat_beats,
    output logic [15:0]                   stat_stall
`endif
);

    localparam int IW = NUM_REQ > 1 ? $clog2(NUM_REQ) : 1;
    localparam int BW = $clog2(BURST_LEN + 1);

    arb_state_e    state, state_n;
    logic [IW-1:0] owner, owner_n, last_owner, last_owner_n, pick;
    logic [BW-1:0] beat_cnt, beat_cnt_n;
    logic          found, transfer, rel;

    // While granted the search starts after the current owner, so a release re-grants without a bubble.
    rr_priority_picker #(.NUM_REQ(NUM_REQ), .IW(IW)) u_picker (
        .valid (req_valid),
        .last  (busy ? owner : last_owner),
        .idx   (pick),
        .found (found)
    );

    assign busy         = state == GRANT;
    assign gnt          = busy ? NUM_REQ'(1) << owner : '0;
    assign transfer     = busy & req_valid[owner] & ~fifo_full;
    assign req_ready    = fifo_full ? '0 : gnt;
    assign fifo_wr_en   = transfer;
    assign fifo_data_in = busy ? req_data[int'(owner)*FIFO_WIDTH +: FIFO_WIDTH] : '0;
    assign rel          = busy & (~req_valid[owner] | (transfer & beat_cnt == BW'(BURST_LEN - 1)));

    always_comb begin
        state_n      = state;
        owner_n      = owner;
        last_owner_n = last_owner;
        beat_cnt_n   = beat_cnt;
        if (!busy) begin
            if (found) begin
                state_n    = GRANT;
                owner_n    = pick;
                beat_cnt_n = '0;
            end
        end else if (rel) begin
            last_owner_n = owner;
            beat_cnt_n   = '0;
            state_n      = found ? GRANT : IDLE;
            owner_n      = found ? pick : owner;
        end else if (transfer) begin
            beat_cnt_n = beat_cnt + BW'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= IDLE;
            owner        <= '0;
            last_owner   <= IW'(NUM_REQ - 1);
            beat_cnt     <= '0;
            err_overflow <= 1'b0;
        end else begin
            state        <= state_n;
            owner        <= owner_n;
            last_owner   <= last_owner_n;
            beat_cnt     <= beat_cnt_n;
            err_overflow <= err_overflow | fifo_overflow;
        end
    end

`ifdef FIFO_ARB_STATS_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stat_beats <= '0;
            stat_stall <= '0;
        end else begin
            for (int i = 0; i < NUM_REQ; i++)
                if (transfer && owner == IW'(i) && stat_beats[i*16 +: 16] != 16'hFFFF)
                    stat_beats[i*16 +: 16] <= stat_beats[i*16 +: 16] + 16'd1;
            if (busy && req_valid[owner] && fifo_full && stat_stall != 16'hFFFF)
                stat_stall <= stat_stall + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// tb_fifo_wr_arbiter: random producers and a depth-8 FIFO checked against a burst round-robin reference model.
module tb_fifo_wr_arbiter;

    localparam int N = 4, W = 16, BL = 4, DEPTH = 8;

    logic           clk = 1'b0, rst_n = 1'b0;
    logic [N-1:0]   req_valid = '0, req_ready, gnt;
    logic [N*W-1:0] req_data = '0;
    logic [W-1:0]   fifo_data_in;
    logic           fifo_wr_en, busy, err_overflow;
    logic           fifo_full = 1'b0, fifo_overflow = 1'b0;
`ifdef FIFO_ARB_STATS_EN
    logic [N*16-1:0] stat_beats;
    logic [15:0]     stat_stall;
`endif

    fifo_wr_arbiter #(.NUM_REQ(N), .FIFO_WIDTH(W), .BURST_LEN(BL)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .req_valid     (req_valid),
        .req_data      (req_data),
        .req_ready     (req_ready),
        .gnt           (gnt),
        .fifo_data_in  (fifo_data_in),
        .fifo_wr_en    (fifo_wr_en),
        .fifo_full     (fifo_full),
        .fifo_overflow (fifo_overflow),
        .busy          (busy),
        .err_overflow  (err_overflow)
`ifdef FIFO_ARB_STATS_EN
       ,.stat_beats    (stat_beats),
        .stat_stall    (stat_stall)
`endif
    );

    always #5 clk = ~clk;

    int checks = 0, errors = 0;

    bit         m_busy, m_err, seq;
    int         m_owner, m_beats, m_last;
    bit         pv[N];
    logic [W-1:0] pd[N];
    logic [W-1:0] q[$];
    int         p_new, p_keep, p_pop;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic int rr_ref(input int last);
        for (int k = 1; k <= N; k++)
            if (pv[(last + k) % N]) return (last + k) % N;
        return -1;
    endfunction

    task automatic reset_model();
        m_busy  = 0;
        m_owner = 0;
        m_beats = 0;
        m_last  = N - 1;
        m_err   = 0;
    endtask

    task automatic drive();
        for (int i = 0; i < N; i++) begin
            req_valid[i]       = pv[i];
            req_data[i*W +: W] = pd[i];
        end
        fifo_full = q.size() >= DEPTH;
    endtask

    task automatic step();
        logic [N-1:0] eg;
        bit t;
        int acc, p;
        drive();
        #1;
        eg = m_busy ? N'(1) << m_owner : '0;
        t  = m_busy && pv[m_owner] && !fifo_full;
        check("gnt", gnt, eg);
        check("busy", busy, m_busy);
        check("req_ready", req_ready, fifo_full ? '0 : eg);
        check("fifo_wr_en", fifo_wr_en, t);
        check("fifo_data_in", fifo_data_in, m_busy ? pd[m_owner] : '0);
        check("err_overflow", err_overflow, m_err);
        if (fifo_wr_en) q.push_back(fifo_data_in);
        if (fifo_overflow) m_err = 1;
        acc = t ? m_owner : -1;
        if (!m_busy) begin
            p = rr_ref(m_last);
            if (p >= 0) begin
                m_busy  = 1;
                m_owner = p;
                m_beats = 0;
            end
        end else begin
            if (t) m_beats++;
            if (m_beats == BL || !pv[m_owner]) begin
                m_last  = m_owner;
                m_beats = 0;
                p = rr_ref(m_owner);
                if (p >= 0) m_owner = p;
                else m_busy = 0;
            end
        end
        for (int i = 0; i < N; i++) begin
            if (i == acc) begin
                if (seq) begin
                    pd[i] = pd[i] + 1'b1;
                    pv[i] = (pd[i] <= 16'hA5);
                end else begin
                    pv[i] = $urandom_range(99) < p_keep;
                    pd[i] = W'($urandom);
                end
            end else if (!pv[i] && $urandom_range(99) < p_new) begin
                pv[i] = 1;
                pd[i] = W'($urandom);
            end
        end
        if (q.size() > 0 && $urandom_range(99) < p_pop) void'(q.pop_front());
        @(negedge clk);
    endtask

    initial begin
        reset_model();
        seq = 0; p_new = 0; p_keep = 0; p_pop = 0;
        for (int i = 0; i < N; i++) begin
            pv[i] = 0;
            pd[i] = '0;
        end
        repeat (2) @(negedge clk);
        #1;
        check("rst_gnt", gnt, '0);
        check("rst_busy", busy, 1'b0);
        check("rst_wr_en", fifo_wr_en, 1'b0);
        check("rst_ready", req_ready, '0);
        check("rst_err", err_overflow, 1'b0);
        rst_n = 1'b1;
        @(negedge clk);

        seq = 1; pv[0] = 1; pd[0] = 16'hA0;
        repeat (10) step();
        check("seq_len", q.size(), 6);
        for (int k = 0; k < 6 && k < q.size(); k++) check("seq_word", q[k], 16'hA0 + k);
        q.delete();
        seq = 0;

        for (int i = 0; i < N; i++) begin
            pv[i] = 1;
            pd[i] = W'($urandom);
        end
        p_new = 100; p_keep = 100; p_pop = 100;
        repeat (40) step();

        p_new = 50; p_keep = 60; p_pop = 30;
        repeat (300) step();
        fifo_overflow = 1'b1;
        step();
        fifo_overflow = 1'b0;
        repeat (300) step();
        p_pop = 10;
        repeat (200) step();

        p_pop = 60;
        for (int c = 0; c < 500 && !(m_busy && m_beats == 2); c++) step();
        check("beat2_reached", m_busy && m_beats == 2, 1'b1);
        drive();
        #2 rst_n = 1'b0;
        #1;
        check("async_gnt", gnt, '0);
        check("async_wr_en", fifo_wr_en, 1'b0);
        check("async_busy", busy, 1'b0);
        check("async_err", err_overflow, 1'b0);
        reset_model();
        @(negedge clk);
        rst_n = 1'b1;
        repeat (400) step();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
